// File: rtl/arb_rr2_gea0_if.sv
// Handshake bundle for the two-input round-robin arbiter. The arbiter keeps
// flat ports so its port list stays fixed. Any block that sits around the
// arbiter connects through this bundle.
interface arb_rr2_gea0_if #(
    parameter int WIDTH = 1
);
    logic             req0_vld;
    logic [WIDTH-1:0] req0_data;
    logic             req0_rdy;
    logic             req1_vld;
    logic [WIDTH-1:0] req1_data;
    logic             req1_rdy;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_rdy;
    logic             sel;

    // Requesters and the downstream sink.
    modport master (
        output req0_vld, req0_data, req1_vld, req1_data, out_rdy,
        input  req0_rdy, req1_rdy, out_vld, out_data, out_src, sel
    );

    // The arbiter itself.
    modport slave (
        input  req0_vld, req0_data, req1_vld, req1_data, out_rdy,
        output req0_rdy, req1_rdy, out_vld, out_data, out_src, sel
    );
endinterface

// File: rtl/mux_n2x1_gea0.sv
// Generic N-bit 2:1 multiplexer cell.
module mux_n2x1_gea0 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? i1 : i0;
endmodule

// File: rtl/arb_rr2_gea0.sv
// Two-channel round-robin arbiter with a single-entry registered output.
// It also keeps a saturating grant counter for each source.
module arb_rr2_gea0 #(
    parameter int WIDTH = 1,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_vld,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_rdy,
    output logic             sel,
    input  logic             cnt_clr,
    output logic [CNTW-1:0]  gnt_cnt0,
    output logic [CNTW-1:0]  gnt_cnt1
);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic             prio;      // channel that wins the next contested cycle
    logic             load_en;   // output slot is free or draining this cycle
    logic             gnt_vld;
    logic             gnt_idx;
    logic             both_vld;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    // Grant decision, handshakes and the load enable for the output slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would infer a latch.
        gnt_vld  = 1'b0;
        gnt_idx  = 1'b0;
        sel      = prio;
        req0_rdy = 1'b0;
        req1_rdy = 1'b0;

        both_vld = req0_vld & req1_vld;
        load_en  = ~out_vld | out_rdy;

        if (both_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = prio;
        end else if (req0_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b0;
        end else if (req1_vld) begin
            gnt_vld = 1'b1;
            gnt_idx = 1'b1;
        end

        if (gnt_vld) begin
            sel = gnt_idx;
        end

        // rst_n gates the handshakes so no transfer is offered during reset.
        req0_rdy = rst_n & load_en & req0_vld & ~gnt_idx;
        req1_rdy = rst_n & load_en & req1_vld &  gnt_idx;

        xfer = req0_rdy | req1_rdy;
    end

    // Winner data select through the shared mux cell.
    mux_n2x1_gea0 #(
        .WIDTH (WIDTH)
    ) u_data_mux (
        .sel (sel),
        .i0  (req0_data),
        .i1  (req1_data),
        .y   (mux_data)
    );

    // Output slot: a load replaces the entry, a drain alone clears the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the values from before the edge.
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_src  <= 1'b0;
        end else if (xfer) begin
            out_vld  <= 1'b1;
            out_data <= mux_data;
            out_src  <= sel;
        end else if (out_rdy) begin
            out_vld  <= 1'b0;
        end
    end

    // Priority flips only when a contested transfer actually took place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (xfer && both_vld) begin
            prio <= ~gnt_idx;
        end
    end

    // Saturating grant counters. A clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (cnt_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (req0_rdy && gnt_cnt0 != CNT_MAX) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (req1_rdy && gnt_cnt1 != CNT_MAX) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arb_rr2_gea0.sv
// Directed testbench for arb_rr2_gea0 with WIDTH=4 and CNTW=2.
module tb_arb_rr2_gea0;
    localparam int WIDTH = 4;
    localparam int CNTW  = 2;

    logic            clk;
    logic            rst_n;
    logic            cnt_clr;
    logic [CNTW-1:0] gnt_cnt0;
    logic [CNTW-1:0] gnt_cnt1;

    int checks;
    int errors;

    arb_rr2_gea0_if #(.WIDTH(WIDTH)) bus ();

    arb_rr2_gea0 #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_vld  (bus.req0_vld),
        .req0_data (bus.req0_data),
        .req0_rdy  (bus.req0_rdy),
        .req1_vld  (bus.req1_vld),
        .req1_data (bus.req1_data),
        .req1_rdy  (bus.req1_rdy),
        .out_vld   (bus.out_vld),
        .out_data  (bus.out_data),
        .out_src   (bus.out_src),
        .out_rdy   (bus.out_rdy),
        .sel       (bus.sel),
        .cnt_clr   (cnt_clr),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checks run on every falling edge: the two rdy outputs are never high
    // together, and a held entry stays stable.
    logic             prev_held;
    logic [WIDTH-1:0] prev_data;
    logic             prev_src;
    initial prev_held = 1'b0;
    always @(negedge clk) begin
        checks++;
        if (bus.req0_rdy && bus.req1_rdy) begin
            errors++;
            $display("FAIL mon_both_rdy at %0t: req0_rdy=1 req1_rdy=1, expected at most one", $time);
        end
        if (prev_held && rst_n) begin
            checks++;
            if (bus.out_data !== prev_data || bus.out_src !== prev_src) begin
                errors++;
                $display("FAIL mon_hold_stable at %0t: data=%h src=%0d, expected data=%h src=%0d",
                         $time, bus.out_data, bus.out_src, prev_data, prev_src);
            end
        end
        prev_held = rst_n && bus.out_vld && !bus.out_rdy;
        prev_data = bus.out_data;
        prev_src  = bus.out_src;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_vld  = 1'b0;
        bus.req1_vld  = 1'b0;
        bus.req0_data = '0;
        bus.req1_data = '0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        cnt_clr     = 1'b0;
        bus.out_rdy = 1'b1;
        bus.req0_vld = 1'b1; bus.req0_data = 4'h9;
        bus.req1_vld = 1'b1; bus.req1_data = 4'h6;
        #3;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: vld=%0d data=%h src=%0d, expected 0/0/0",
                     bus.out_vld, bus.out_data, bus.out_src);
        end
        checks++;
        if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: cnt0=%0d cnt1=%0d, expected 0/0", gnt_cnt0, gnt_cnt1);
        end
        checks++;
        if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdy: rdy0=%0d rdy1=%0d, expected 0/0", bus.req0_rdy, bus.req1_rdy);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_load: out_vld=%0d, expected 0", bus.out_vld);
        end
        idle_inputs();
        #4 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: out_vld=%0d, expected 0", bus.out_vld);
        end
    endtask

    // Both requesters valid with a free sink: grants alternate 0,1,0,1.
    task automatic test_alternate();
        logic exp_src;
        logic [WIDTH-1:0] exp_data;
        bus.req0_vld = 1'b1; bus.req0_data = 4'hA;
        bus.req1_vld = 1'b1; bus.req1_data = 4'hB;
        bus.out_rdy  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_src  = (k % 2 == 1);
            exp_data = exp_src ? 4'hB : 4'hA;
            #1;
            checks++;
            if (bus.sel !== exp_src || bus.req0_rdy !== !exp_src || bus.req1_rdy !== exp_src) begin
                errors++;
                $display("FAIL alt_grant[%0d]: sel=%0d rdy0=%0d rdy1=%0d, expected sel=%0d",
                         k, bus.sel, bus.req0_rdy, bus.req1_rdy, exp_src);
            end
            tick();
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_src !== exp_src || bus.out_data !== exp_data) begin
                errors++;
                $display("FAIL alt_out[%0d]: vld=%0d src=%0d data=%h, expected 1/%0d/%h",
                         k, bus.out_vld, bus.out_src, bus.out_data, exp_src, exp_data);
            end
        end
        checks++;
        if (gnt_cnt0 !== 2'd2 || gnt_cnt1 !== 2'd2) begin
            errors++;
            $display("FAIL alt_cnt: cnt0=%0d cnt1=%0d, expected 2/2", gnt_cnt0, gnt_cnt1);
        end
        // A drain with no new request clears valid and keeps the last entry.
        idle_inputs();
        tick();
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_src !== 1'b1 || bus.out_data !== 4'hB) begin
            errors++;
            $display("FAIL drain_only: vld=%0d src=%0d data=%h, expected 0/1/b",
                     bus.out_vld, bus.out_src, bus.out_data);
        end
    endtask

    // A single requester must not move prio. The next contested grant goes to 0.
    task automatic test_single_req();
        bus.req1_vld = 1'b1; bus.req1_data = 4'h5;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.sel !== 1'b1 || bus.req1_rdy !== 1'b1 || bus.req0_rdy !== 1'b0) begin
                errors++;
                $display("FAIL single_grant[%0d]: sel=%0d rdy0=%0d rdy1=%0d, expected 1/0/1",
                         k, bus.sel, bus.req0_rdy, bus.req1_rdy);
            end
            tick();
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_src !== 1'b1 || bus.out_data !== 4'h5) begin
                errors++;
                $display("FAIL single_out[%0d]: vld=%0d src=%0d data=%h, expected 1/1/5",
                         k, bus.out_vld, bus.out_src, bus.out_data);
            end
        end
        checks++;
        if (gnt_cnt1 !== 2'd3) begin
            errors++;
            $display("FAIL single_cnt1_sat: cnt1=%0d, expected 3", gnt_cnt1);
        end
        bus.req0_vld = 1'b1; bus.req0_data = 4'h3;
        #1;
        checks++;
        if (bus.sel !== 1'b0 || bus.req0_rdy !== 1'b1 || bus.req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_then_both: sel=%0d rdy0=%0d rdy1=%0d, expected 0/1/0",
                     bus.sel, bus.req0_rdy, bus.req1_rdy);
        end
        tick();
        checks++;
        if (bus.out_src !== 1'b0 || bus.out_data !== 4'h3 || gnt_cnt0 !== 2'd3) begin
            errors++;
            $display("FAIL single_then_both_out: src=%0d data=%h cnt0=%0d, expected 0/3/3",
                     bus.out_src, bus.out_data, gnt_cnt0);
        end
    endtask

    // Stalled sink holds the entry. Releasing it drains and loads in one cycle.
    task automatic test_back_to_back();
        bus.out_rdy  = 1'b0;
        bus.req0_vld = 1'b1; bus.req0_data = 4'h6;
        bus.req1_vld = 1'b1; bus.req1_data = 4'h7;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_rdy[%0d]: rdy0=%0d rdy1=%0d, expected 0/0",
                         k, bus.req0_rdy, bus.req1_rdy);
            end
            tick();
            checks++;
            if (bus.out_vld !== 1'b1 || bus.out_src !== 1'b0 || bus.out_data !== 4'h3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld=%0d src=%0d data=%h, expected 1/0/3",
                         k, bus.out_vld, bus.out_src, bus.out_data);
            end
        end
        bus.out_rdy = 1'b1;
        #1;
        checks++;
        if (bus.req1_rdy !== 1'b1 || bus.req0_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rdy: rdy0=%0d rdy1=%0d, expected 0/1", bus.req0_rdy, bus.req1_rdy);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_src !== 1'b1 || bus.out_data !== 4'h7) begin
            errors++;
            $display("FAIL b2b_replace: vld=%0d src=%0d data=%h, expected 1/1/7",
                     bus.out_vld, bus.out_src, bus.out_data);
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_vld=%0d, expected 0", bus.out_vld);
        end
    endtask

    // Counter saturation at CNTW=2, and a clear that wins over a grant.
    task automatic test_counter();
        logic [CNTW-1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (gnt_cnt0 !== 2'd0 || gnt_cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clear: cnt0=%0d cnt1=%0d, expected 0/0", gnt_cnt0, gnt_cnt1);
        end
        bus.req0_vld = 1'b1; bus.req0_data = 4'hC;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (gnt_cnt0 !== exp_cnt[k] || gnt_cnt1 !== 2'd0) begin
                errors++;
                $display("FAIL cnt_sat[%0d]: cnt0=%0d cnt1=%0d, expected %0d/0",
                         k, gnt_cnt0, gnt_cnt1, exp_cnt[k]);
            end
        end
        cnt_clr = 1'b1;
        #1;
        checks++;
        if (bus.req0_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clr_grant_rdy: rdy0=%0d, expected 1", bus.req0_rdy);
        end
        tick();
        cnt_clr = 1'b0;
        checks++;
        if (gnt_cnt0 !== 2'd0 || bus.out_src !== 1'b0 || bus.out_data !== 4'hC) begin
            errors++;
            $display("FAIL cnt_clr_override: cnt0=%0d src=%0d data=%h, expected 0/0/c",
                     gnt_cnt0, bus.out_src, bus.out_data);
        end
        idle_inputs();
        tick();
    endtask

    // Reset between edges while an entry is held, then check the first contested grant.
    task automatic test_async_reset();
        bus.req0_vld = 1'b1; bus.req0_data = 4'hD;
        bus.req1_vld = 1'b1; bus.req1_data = 4'hE;
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_src !== 1'b0 || gnt_cnt0 !== 2'd1) begin
            errors++;
            $display("FAIL areset_pre: vld=%0d src=%0d cnt0=%0d, expected 1/0/1",
                     bus.out_vld, bus.out_src, gnt_cnt0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 4'h0 || gnt_cnt0 !== 2'd0 ||
            bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: vld=%0d data=%h cnt0=%0d rdy0=%0d rdy1=%0d, expected all 0",
                     bus.out_vld, bus.out_data, gnt_cnt0, bus.req0_rdy, bus.req1_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.sel !== 1'b0 || bus.req0_rdy !== 1'b1 || bus.req1_rdy !== 1'b0) begin
            errors++;
            $display("FAIL areset_prio: sel=%0d rdy0=%0d rdy1=%0d, expected 0/1/0",
                     bus.sel, bus.req0_rdy, bus.req1_rdy);
        end
        tick();
        checks++;
        if (bus.out_src !== 1'b0 || bus.out_data !== 4'hD || gnt_cnt0 !== 2'd1 || gnt_cnt1 !== 2'd0) begin
            errors++;
            $display("FAIL areset_first: src=%0d data=%h cnt0=%0d cnt1=%0d, expected 0/d/1/0",
                     bus.out_src, bus.out_data, gnt_cnt0, gnt_cnt1);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alternate();
        test_single_req();
        test_back_to_back();
        test_counter();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb_rr2_gea0.md
ARB_RR2_GEA0 -- requirements
Module: arb_rr2_gea0

Interface
REQ-001 SHALL have parameter WIDTH, default 1: data width of both input channels and the output channel.
REQ-002 SHALL have parameter CNTW, default 16: width of each per-source grant counter.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; all state changes on the rising clk edge.
REQ-004 Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req0_vld  input  1  channel 0 data valid
- req0_data  input  WIDTH  channel 0 data
- req0_rdy  output  1  channel 0 accepted this cycle
- req1_vld  input  1  channel 1 data valid
- req1_data  input  WIDTH  channel 1 data
- req1_rdy  output  1  channel 1 accepted this cycle
- out_vld  output  1  output register holds data
- out_data  output  WIDTH  registered winner data
- out_src  output  1  source index of out_data
- out_rdy  input  1  downstream accepts out_data
- sel  output  1  combinational grant index, drives the 2:1 data mux
- cnt_clr  input  1  synchronous clear of grant counters
- gnt_cnt0  output  CNTW  channel 0 grant count
- gnt_cnt1  output  CNTW  channel 1 grant count

Function
REQ-005 SHALL hold one output entry (out_vld, out_data, out_src); no other data storage.
REQ-006 load_en SHALL be (!out_vld | out_rdy); a new entry loads only when load_en=1.
REQ-007 Arbitration, combinational: only req0_vld -> grant 0; only req1_vld -> grant 1; both -> grant = prio; neither -> no grant.
REQ-008 sel SHALL equal the grant index when a grant exists, otherwise prio.
REQ-009 reqN_rdy SHALL be 1 only when load_en=1, reqN_vld=1 and grant=N; never both rdy high in one cycle.
REQ-010 On a transfer (reqN_vld & reqN_rdy): out_data <= reqN_data, out_src <= N, out_vld <= 1 at the next edge; latency 1 cycle.
REQ-011 If out_vld & out_rdy and no input transfer, out_vld SHALL go 0 at the next edge; out_data/out_src hold their values.
REQ-012 Simultaneous drain and load SHALL replace the entry with no bubble: sustained throughput 1 transfer/cycle.
REQ-013 prio SHALL update only on a transfer where both requests were valid: prio <= ~grant. A single-requester transfer leaves prio unchanged.
REQ-014 While out_vld=1 and out_rdy=0, out_data and out_src SHALL be stable and both rdy outputs 0.
REQ-015 gnt_cntN SHALL increment by 1 on each channel-N transfer and saturate at all-ones (no wrap).
REQ-016 cnt_clr=1 SHALL zero both counters at the next edge; cnt_clr overrides a simultaneous increment.
REQ-017 Input valids are not required to be held; a dropped request is simply not granted.

Reset
REQ-018 rst_n=0 SHALL asynchronously force out_vld=0, out_data=0, out_src=0, prio=0, gnt_cnt0=0 and gnt_cnt1=0.
REQ-019 During reset, req0_rdy=req1_rdy=0. Reset mid-transfer discards the held entry; no transfer is reported.
REQ-020 The first grant after reset release, with both requests valid, SHALL go to channel 0.

Structure
REQ-021 The data path select SHALL instantiate the generic 2:1 mux cell mux_n2x1_gea0 (WIDTH passed through), with sel on its select input and req0_data/req1_data on i0/i1.
REQ-022 No shared package; WIDTH and CNTW are the only constants and stay module parameters.
REQ-023 Target size: 120-250 lines of RTL; no other sub-modules.

Verification
REQ-024 Scenario: reset; both vld=1 with data 0xA/0xB (WIDTH=4), out_rdy=1 for 4 cycles -> out_src sequence 0,1,0,1 and out_data A,B,A,B, one per cycle.
REQ-025 Scenario: only req1_vld=1 for 3 cycles, then both valid -> three grants to 1, prio still 0, next grant to 0.
REQ-026 Scenario: out_rdy=0 with an entry held, both vld=1 for 5 cycles -> both rdy=0, out_data stable; out_rdy=1 -> drain and load in the same cycle.
REQ-027 Scenario: CNTW=2, 5 grants to channel 0 -> gnt_cnt0 = 1,2,3,3,3; cnt_clr together with a grant -> 0.
REQ-028 Scenario: assert rst_n=0 asynchronously between edges with out_vld=1 -> out_vld=0 immediately; prio=0 and counters=0 after release.
REQ-029 Assertions: never req0_rdy & req1_rdy; out_data stable while out_vld & !out_rdy.
